debounce_multi: RTL



---
 rtl/debounce_multi_if.sv | 22 ++
 rtl/debounce_multi.sv | 86 ++++++++
 2 files changed

// File: rtl/debounce_multi_if.sv
// Switch-side and event-side signals of the multi-channel debouncer.
// The master drives the raw switches and the mode; the slave is the filter.
interface debounce_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] switchin;
    logic              sym_en;
    logic [NUM_CH-1:0] switchout;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic              sample_tick;

    modport master (
        output switchin, sym_en,
        input  switchout, rise_pulse, fall_pulse, sample_tick
    );

    modport slave (
        input  switchin, sym_en,
        output switchout, rise_pulse, fall_pulse, sample_tick
    );
endinterface

// File: rtl/debounce_multi.sv
// NUM_CH switch debouncers sharing one sample prescaler, with edge pulses.
// Latency: sync + tick wait + (PULSE_CNT_MAX-1) tick periods + 1; no backpressure.
module debounce_multi #(
    parameter int                NUM_CH        = 4,
    parameter int                SMP_CNT_MAX   = 100,
    parameter int                PULSE_CNT_MAX = 10,
    parameter int                CNT_W         = 8,
    parameter int                SYNC_STAGES   = 2,
    parameter logic [NUM_CH-1:0] RST_VAL       = '0
) (
    input logic             iclk,
    input logic             irst_n,
    debounce_multi_if.slave bus
);
    localparam int                SMP_W    = (SMP_CNT_MAX < 1) ? 1 : $clog2(SMP_CNT_MAX + 1);
    localparam logic [SMP_W-1:0]  SMP_TERM = SMP_W'(SMP_CNT_MAX);
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(PULSE_CNT_MAX - 1);

    logic [NUM_CH-1:0] sync_r [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_q;
    logic [SMP_W-1:0]  smp_cnt;
    logic              tick_r;
    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [NUM_CH-1:0] sw_r;
    logic [NUM_CH-1:0] rise_r;
    logic [NUM_CH-1:0] fall_r;

    // Raw pins go straight into the first flop to keep metastability contained.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= RST_VAL;
        end else begin
            sync_r[0] <= bus.switchin;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            smp_cnt <= '0;
            tick_r  <= 1'b0;
        end else if (smp_cnt == SMP_TERM) begin
            smp_cnt <= '0;
            tick_r  <= 1'b1;
        end else begin
            smp_cnt <= smp_cnt + SMP_W'(1);
            tick_r  <= 1'b0;
        end
    end

    // A mismatch must survive PULSE_CNT_MAX consecutive ticks; any agreement restarts it.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sw_r   <= RST_VAL;
            rise_r <= '0;
            fall_r <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) cnt_r[ch] <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rise_r[ch] <= 1'b0;
                fall_r[ch] <= 1'b0;
                if (sync_q[ch] == sw_r[ch]) begin
                    cnt_r[ch] <= '0;
                end else if (!bus.sym_en && !sync_q[ch]) begin
                    sw_r[ch]   <= 1'b0;
                    fall_r[ch] <= 1'b1;
                    cnt_r[ch]  <= '0;
                end else if (tick_r && (cnt_r[ch] == CNT_TERM)) begin
                    sw_r[ch]   <= sync_q[ch];
                    rise_r[ch] <= sync_q[ch];
                    fall_r[ch] <= ~sync_q[ch];
                    cnt_r[ch]  <= '0;
                end else if (tick_r) begin
                    cnt_r[ch] <= cnt_r[ch] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.switchout   = sw_r;
    assign bus.rise_pulse  = rise_r;
    assign bus.fall_pulse  = fall_r;
    assign bus.sample_tick = tick_r;
endmodule
